// File: rtl/if_fetch_buffer.sv
// Instruction-fetch stage: owns the PC, issues in-order fetches on the req/gnt/rvalid port
// and buffers returned words with their PCs in a small FIFO toward the decoder.
module if_fetch_buffer #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = CW + OW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] disc_q, disc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic          rsp_ok, push, pop, req, fire;
  logic [SW-1:0] live_plus_cnt;
  logic [31:0]   target_pc;

  // outstanding includes words already marked for discard; only live ones need FIFO room
  assign live_plus_cnt = SW'(outst_q) - SW'(disc_q) + SW'(count_q);
  assign rsp_ok        = imem_rvalid_i & (outst_q != '0);
  assign push          = rsp_ok & (disc_q == '0) & ~redirect_i;
  assign pop           = (count_q != '0) & id_ready_i & ~redirect_i;
  assign req           = rst_ni & ~redirect_i & (outst_q < OW'(MAX_OUTSTANDING))
                         & (live_plus_cnt < SW'(DEPTH));
  assign fire          = req & imem_gnt_i;
  assign target_pc     = {redirect_pc_i[31:2], 2'b00};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    disc_d     = disc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    outst_d    = outst_q + OW'(fire) - OW'(rsp_ok);
    if (fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (redirect_i) begin
      // everything still in flight after this edge belongs to the old path
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      disc_d     = outst_q - OW'(rsp_ok);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (rsp_ok && disc_q != '0) begin
        disc_d = disc_q - OW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is not reset: entries are only visible while count_q says they are valid
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc_q;
  assign id_valid_o  = (count_q != '0);
  assign id_pc_o     = id_valid_o ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign id_inst_o   = id_valid_o ? inst_mem_q[rd_ptr_q] : NOP;

endmodule
